// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the data-memory path: word type and the responder FSM states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } dresp_state_t;

  // Word accesses need the two byte-offset bits clear.
  function automatic logic is_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Saturating wait counter for RAM accesses; flags the terminal count at TIMEOUT-1.
module wait_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: turns dREN/dWEN level requests into one RAM access and a one-cycle dhit.
module dmem_responder
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = WORD_W,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              derr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_store,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_load
);

  dresp_state_t state, next_state;
  logic         op_write;
  logic         err;
  logic         req;
  logic         aligned;
  logic         cnt_tc;

  assign req     = dREN | dWEN;
  assign aligned = is_aligned(daddr[1:0]);

  wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (state == IDLE),
    .enable (state == REQ),
    .tc     (cnt_tc)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = aligned ? REQ : RESP;
      REQ:     if (mem_ready || cnt_tc) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latches and the load register; the pipeline-side inputs are only looked at in IDLE.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mem_addr  <= '0;
      mem_store <= '0;
      op_write  <= 1'b0;
      err       <= 1'b0;
      dload     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            mem_addr  <= daddr;
            mem_store <= dstore;
            op_write  <= dWEN;
            err       <= !aligned;
          end
        end
        REQ: begin
          // Ready is checked first so a completion in the abort cycle still counts as good.
          if (mem_ready) begin
            if (!op_write) dload <= mem_load;
            err <= 1'b0;
          end else if (cnt_tc) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    dhit    = 1'b0;
    derr    = 1'b0;
    case (state)
      REQ: begin
        mem_ren = !op_write;
        mem_wen = op_write;
      end
      RESP: begin
        dhit = 1'b1;
        derr = err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reads, writes, misalignment, timeout, reset abort, back-to-back.
module tb_dmem_responder;

  logic        CLK;
  logic        nRST;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        derr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_store;
  logic        mem_ready;
  logic [31:0] mem_load;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dhit      (dhit),
    .dload     (dload),
    .derr      (derr),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_store (mem_store),
    .mem_ready (mem_ready),
    .mem_load  (mem_load)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int ren_cnt;
    int hit_seen;
    int nhits;
    int hit_cycle [2];

    nRST = 1'b0; dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    mem_ready = 1'b0; mem_load = '0;
    tick(); tick();
    check("rst_dhit", dhit, 0);
    check("rst_derr", derr, 0);
    check("rst_dload", dload, 0);
    check("rst_mem_ren", mem_ren, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    nRST = 1'b1;
    tick();

    // 1: read 0x100, ready in the third REQ cycle
    dREN = 1'b1; daddr = 32'h100;
    tick();
    check("t1_ren_c1", mem_ren, 1);
    check("t1_addr", mem_addr, 32'h100);
    tick();
    check("t1_ren_c2", mem_ren, 1);
    tick();
    check("t1_ren_c3", mem_ren, 1);
    check("t1_no_early_hit", dhit, 0);
    mem_ready = 1'b1; mem_load = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b0;
    check("t1_dhit", dhit, 1);
    check("t1_derr", derr, 0);
    check("t1_dload", dload, 32'hDEADBEEF);
    check("t1_ren_off", mem_ren, 0);
    dREN = 1'b0;
    tick();
    check("t1_dhit_one_cycle", dhit, 0);

    // 2: write 0x204, ready in the first REQ cycle; dload must not change
    dWEN = 1'b1; daddr = 32'h204; dstore = 32'h12345678;
    tick();
    check("t2_wen", mem_wen, 1);
    check("t2_ren", mem_ren, 0);
    check("t2_store", mem_store, 32'h12345678);
    check("t2_addr", mem_addr, 32'h204);
    mem_ready = 1'b1; mem_load = 32'hAAAAAAAA;
    tick();
    mem_ready = 1'b0;
    check("t2_dhit", dhit, 1);
    check("t2_derr", derr, 0);
    check("t2_dload_kept", dload, 32'hDEADBEEF);
    dWEN = 1'b0;
    tick();

    // 3: misaligned read, no RAM strobe, error response next cycle
    dREN = 1'b1; daddr = 32'h103;
    tick();
    check("t3_no_ren", mem_ren, 0);
    check("t3_dhit", dhit, 1);
    check("t3_derr", derr, 1);
    dREN = 1'b0;
    tick();
    check("t3_idle", dhit, 0);

    // 4: read with no ready, aborts after 8 REQ cycles
    dREN = 1'b1; daddr = 32'h300;
    ren_cnt = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (mem_ren) ren_cnt++;
      tick();
    end
    check("t4_ren_cycles", ren_cnt, 8);
    check("t4_ren_off", mem_ren, 0);
    check("t4_dhit", dhit, 1);
    check("t4_derr", derr, 1);
    check("t4_dload_kept", dload, 32'hDEADBEEF);
    dREN = 1'b0;
    tick();

    // 4b: ready in the abort cycle wins
    dREN = 1'b1; daddr = 32'h600;
    tick();
    for (int i = 0; i < 7; i++) tick();
    check("t4b_ren_c8", mem_ren, 1);
    mem_ready = 1'b1; mem_load = 32'h55AA55AA;
    tick();
    mem_ready = 1'b0;
    check("t4b_dhit", dhit, 1);
    check("t4b_derr", derr, 0);
    check("t4b_dload", dload, 32'h55AA55AA);
    dREN = 1'b0;
    tick();

    // 5: reset in the second REQ cycle abandons the access
    dREN = 1'b1; daddr = 32'h400; dstore = 32'hFFFF0000;
    tick();
    tick();
    nRST = 1'b0;
    tick();
    check("t5_dhit", dhit, 0);
    check("t5_derr", derr, 0);
    check("t5_dload", dload, 0);
    check("t5_ren", mem_ren, 0);
    check("t5_wen", mem_wen, 0);
    check("t5_addr", mem_addr, 0);
    check("t5_store", mem_store, 0);
    nRST = 1'b1; dREN = 1'b0;
    hit_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (dhit) hit_seen++;
      tick();
    end
    check("t5_no_stale_hit", hit_seen, 0);
    dREN = 1'b1; daddr = 32'h500;
    tick();
    check("t5_after_ren", mem_ren, 1);
    mem_ready = 1'b1; mem_load = 32'hCAFEF00D;
    tick();
    mem_ready = 1'b0;
    check("t5_after_dhit", dhit, 1);
    check("t5_after_dload", dload, 32'hCAFEF00D);
    dREN = 1'b0;
    tick();

    // 6: both strobes high is a write
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h10; dstore = 32'h0BADF00D;
    tick();
    check("t6_wen_c1", mem_wen, 1);
    check("t6_ren_c1", mem_ren, 0);
    tick();
    check("t6_wen_c2", mem_wen, 1);
    check("t6_ren_c2", mem_ren, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("t6_dhit", dhit, 1);
    check("t6_dload_kept", dload, 32'hCAFEF00D);
    dREN = 1'b0; dWEN = 1'b0;
    tick();

    // 6 cont: back-to-back reads with a one-cycle RAM; requester advances on dhit
    nhits = 0;
    hit_cycle[0] = -1;
    hit_cycle[1] = -1;
    dREN = 1'b1; daddr = 32'h20;
    for (int cyc = 0; cyc < 20; cyc++) begin
      mem_ready = mem_ren;
      mem_load  = 32'h10000000 + 32'(cyc);
      if (dhit) begin
        if (nhits < 2) hit_cycle[nhits] = cyc;
        nhits++;
        if (nhits == 1) daddr = 32'h24;
        else            dREN  = 1'b0;
      end
      tick();
    end
    mem_ready = 1'b0;
    check("b2b_hits", nhits, 2);
    check("b2b_first", hit_cycle[0], 2);
    check("b2b_gap", hit_cycle[1] - hit_cycle[0], 3);
    check("b2b_dload", dload, 32'h10000004);
    check("b2b_addr", mem_addr, 32'h24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
